// File: rtl/riscv_divider_xlen.sv
// rtl/riscv_divider_xlen.sv - iterative restoring divider for DIV/DIVU/REM/REMU
//
// Sits beside the ALU/multiplier in the execute stage. One operation is in
// flight at a time; the issue stage holds a request until ready_o is high.
// Divide-by-zero and signed overflow resolve in the accept cycle and skip
// the iteration phase entirely.
//
// Parameters:
//   XLEN            operand/result width (32 or 64)
//   BITS_PER_CYCLE  quotient bits resolved per iteration (1 or 2)
//
// Ports:
//   clk_i                clock, rising edge
//   rst_i                synchronous active-high reset
//   opcode_valid_i       request valid
//   op_i                 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   opcode_rd_idx_i      destination register tag
//   opcode_ra_operand_i  dividend
//   opcode_rb_operand_i  divisor
//   flush_i              abort any in-flight operation
//   ready_o              unit idle, can accept
//   writeback_valid_o    one-cycle result strobe
//   writeback_value_o    result (held until the next writeback)
//   writeback_rd_idx_o   tag of the completing operation
//
// Optional feature: define DIVIDER_CACHE_EN to keep the operands and results
// of the last completed iterative operation, so a repeat or a DIV/REM pair on
// the same operands completes without iterating.

module riscv_divider_xlen #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            opcode_valid_i,
  input  logic [1:0]      op_i,
  input  logic [4:0]      opcode_rd_idx_i,
  input  logic [XLEN-1:0] opcode_ra_operand_i,
  input  logic [XLEN-1:0] opcode_rb_operand_i,
  input  logic            flush_i,
  output logic            ready_o,
  output logic            writeback_valid_o,
  output logic [XLEN-1:0] writeback_value_o,
  output logic [4:0]      writeback_rd_idx_o
);

  localparam int N  = XLEN / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q;
  logic [XLEN-1:0]   rem_q, quo_q;
  logic [2*XLEN-2:0] dvs_q;
  logic              neg_quo_q, neg_rem_q, is_rem_q;
  logic [4:0]        rd_q;
  logic              wb_valid_q;
  logic [XLEN-1:0]   wb_value_q;
  logic [4:0]        wb_rd_q;

  logic              accept, op_signed, a_neg, b_neg, div_zero, ovf, cache_hit;
  logic [XLEN-1:0]   a_mag, b_mag, result;
  logic [XLEN-1:0]   rem_n, quo_n;
  logic [2*XLEN-2:0] dvs_n;

  assign ready_o   = (state_q == IDLE);
  assign accept    = opcode_valid_i && ready_o && !flush_i;
  assign op_signed = !op_i[0];
  assign a_neg     = op_signed && opcode_ra_operand_i[XLEN-1];
  assign b_neg     = op_signed && opcode_rb_operand_i[XLEN-1];
  assign a_mag     = a_neg ? -opcode_ra_operand_i : opcode_ra_operand_i;
  assign b_mag     = b_neg ? -opcode_rb_operand_i : opcode_rb_operand_i;
  assign div_zero  = (opcode_rb_operand_i == '0);
  assign ovf       = op_signed && (opcode_ra_operand_i == MOST_NEG) &&
                     (opcode_rb_operand_i == '1);

`ifdef DIVIDER_CACHE_EN
  logic            c_valid_q, c_signed_q, norm_q, signed_q;
  logic [XLEN-1:0] c_a_q, c_b_q, c_quo_q, c_rem_q, a_q, b_q;

  // Cached magnitudes are reused; sign fix-up is recomputed from the
  // (identical) operands, so DIV and REM can share an entry.
  assign cache_hit = c_valid_q && (c_a_q == opcode_ra_operand_i) &&
                     (c_b_q == opcode_rb_operand_i) && (c_signed_q == op_signed);
`else
  assign cache_hit = 1'b0;
`endif

  // One restoring step per resolved quotient bit; the divisor slides right
  // through the 2*XLEN-1 alignment register.
  always_comb begin
    rem_n = rem_q;
    quo_n = quo_q;
    dvs_n = dvs_q;
    for (int s = 0; s < BITS_PER_CYCLE; s++) begin
      if ({{(XLEN-1){1'b0}}, rem_n} >= dvs_n) begin
        rem_n = rem_n - dvs_n[XLEN-1:0];
        quo_n = {quo_n[XLEN-2:0], 1'b1};
      end else begin
        quo_n = {quo_n[XLEN-2:0], 1'b0};
      end
      dvs_n = dvs_n >> 1;
    end
  end

  always_comb begin
    result = '0;
    if (is_rem_q) result = neg_rem_q ? -rem_q : rem_q;
    else          result = neg_quo_q ? -quo_q : quo_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = (div_zero || ovf || cache_hit) ? DONE : BUSY;
      BUSY: if (cnt_q == CW'(N - 1)) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_value_q <= '0;
      wb_rd_q    <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      is_rem_q   <= 1'b0;
      rd_q       <= '0;
`ifdef DIVIDER_CACHE_EN
      c_valid_q  <= 1'b0;
      c_signed_q <= 1'b0;
      c_a_q      <= '0;
      c_b_q      <= '0;
      c_quo_q    <= '0;
      c_rem_q    <= '0;
      norm_q     <= 1'b0;
      signed_q   <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
`endif
    end else begin
      state_q    <= state_d;
      wb_valid_q <= 1'b0;
      if (accept) begin
        rd_q     <= opcode_rd_idx_i;
        is_rem_q <= op_i[1];
        cnt_q    <= '0;
        // Special cases load final values with no sign fix-up.
        if (div_zero) begin
          quo_q     <= '1;
          rem_q     <= opcode_ra_operand_i;
          neg_quo_q <= 1'b0;
          neg_rem_q <= 1'b0;
        end else if (ovf) begin
          quo_q     <= MOST_NEG;
          rem_q     <= '0;
          neg_quo_q <= 1'b0;
          neg_rem_q <= 1'b0;
        end else begin
          neg_quo_q <= a_neg ^ b_neg;
          neg_rem_q <= a_neg;
`ifdef DIVIDER_CACHE_EN
          if (cache_hit) begin
            quo_q <= c_quo_q;
            rem_q <= c_rem_q;
          end else begin
            quo_q <= '0;
            rem_q <= a_mag;
            dvs_q <= {b_mag, {(XLEN-1){1'b0}}};
          end
`else
          quo_q <= '0;
          rem_q <= a_mag;
          dvs_q <= {b_mag, {(XLEN-1){1'b0}}};
`endif
        end
`ifdef DIVIDER_CACHE_EN
        a_q      <= opcode_ra_operand_i;
        b_q      <= opcode_rb_operand_i;
        signed_q <= op_signed;
        norm_q   <= !(div_zero || ovf || cache_hit);
`endif
      end
      if (state_q == BUSY) begin
        rem_q <= rem_n;
        quo_q <= quo_n;
        dvs_q <= dvs_n;
        cnt_q <= cnt_q + CW'(1);
      end
      if (state_q == DONE && !flush_i) begin
        wb_valid_q <= 1'b1;
        wb_value_q <= result;
        wb_rd_q    <= rd_q;
`ifdef DIVIDER_CACHE_EN
        if (norm_q) begin
          c_valid_q  <= 1'b1;
          c_a_q      <= a_q;
          c_b_q      <= b_q;
          c_signed_q <= signed_q;
          c_quo_q    <= quo_q;
          c_rem_q    <= rem_q;
        end
`endif
      end
    end
  end

  // A flush in the strobe cycle still cancels the writeback.
  assign writeback_valid_o  = wb_valid_q && !flush_i;
  assign writeback_value_o  = wb_value_q;
  assign writeback_rd_idx_o = wb_rd_q;

endmodule

// File: tb/tb_riscv_divider_xlen.sv
// tb/tb_riscv_divider_xlen.sv - directed vector bench for riscv_divider_xlen
module tb_riscv_divider_xlen;

`ifdef DIVIDER_CACHE_EN
  localparam int CL = 2;
`else
  localparam int CL = 34;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        v32 = 1'b0, fl32 = 1'b0;
  logic [1:0]  op32 = '0;
  logic [4:0]  rd32 = '0;
  logic [31:0] a32 = '0, b32 = '0;
  logic        rdy32, wbv32;
  logic [31:0] wbval32;
  logic [4:0]  wbrd32;

  logic        v64 = 1'b0, fl64 = 1'b0;
  logic [1:0]  op64 = '0;
  logic [4:0]  rd64 = '0;
  logic [63:0] a64 = '0, b64 = '0;
  logic        rdy64, wbv64;
  logic [63:0] wbval64;
  logic [4:0]  wbrd64;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  riscv_divider_xlen #(.XLEN(32), .BITS_PER_CYCLE(1)) dut32 (
    .clk_i(clk), .rst_i(rst), .opcode_valid_i(v32), .op_i(op32),
    .opcode_rd_idx_i(rd32), .opcode_ra_operand_i(a32), .opcode_rb_operand_i(b32),
    .flush_i(fl32), .ready_o(rdy32), .writeback_valid_o(wbv32),
    .writeback_value_o(wbval32), .writeback_rd_idx_o(wbrd32));

  riscv_divider_xlen #(.XLEN(64), .BITS_PER_CYCLE(2)) dut64 (
    .clk_i(clk), .rst_i(rst), .opcode_valid_i(v64), .op_i(op64),
    .opcode_rd_idx_i(rd64), .opcode_ra_operand_i(a64), .opcode_rb_operand_i(b64),
    .flush_i(fl64), .ready_o(rdy64), .writeback_valid_o(wbv64),
    .writeback_value_o(wbval64), .writeback_rd_idx_o(wbrd64));

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
  } vec32_t;

  typedef struct {
    logic [1:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [4:0]  rd;
    logic [63:0] exp;
    int          lat;
  } vec64_t;

  vec32_t vecs[18];
  vec64_t v64s[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge with the unit ready; returns at the negedge of the
  // writeback cycle so the next call can issue back-to-back.
  task automatic run32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, output int lat, output logic [31:0] val,
                       output logic [4:0] rdo, output int rdy_bad);
    v32 = 1'b1; op32 = op; a32 = a; b32 = b; rd32 = rd;
    @(posedge clk); #1 v32 = 1'b0;
    lat = 0; val = '0; rdo = '0; rdy_bad = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (wbv32) begin
        lat = k; val = wbval32; rdo = wbrd32;
        break;
      end
      if (rdy32) rdy_bad++;
    end
  endtask

  task automatic run64(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] rd, output int lat, output logic [63:0] val,
                       output logic [4:0] rdo, output int rdy_bad);
    v64 = 1'b1; op64 = op; a64 = a; b64 = b; rd64 = rd;
    @(posedge clk); #1 v64 = 1'b0;
    lat = 0; val = '0; rdo = '0; rdy_bad = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (wbv64) begin
        lat = k; val = wbval64; rdo = wbrd64;
        break;
      end
      if (rdy64) rdy_bad++;
    end
  endtask

  task automatic count_wb32(input int cycles, output int n);
    n = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (wbv32) n++;
    end
  endtask

  initial begin
    int          lat, bad, nwb;
    logic [31:0] val;
    logic [63:0] val64;
    logic [4:0]  rdo;

    // op: 00 DIV, 01 DIVU, 10 REM, 11 REMU
    vecs[0]  = '{2'b01, 32'd100,      32'd7,        5'd5,  32'd14,       34};
    vecs[1]  = '{2'b00, 32'hFFFFFF9C, 32'd7,        5'd6,  32'hFFFFFFF2, 34};
    vecs[2]  = '{2'b10, 32'hFFFFFF9C, 32'd7,        5'd7,  32'hFFFFFFFE, CL};
    vecs[3]  = '{2'b00, 32'h80000000, 32'hFFFFFFFF, 5'd8,  32'h80000000, 2};
    vecs[4]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 5'd9,  32'h00000000, 2};
    vecs[5]  = '{2'b01, 32'd5,        32'd0,        5'd10, 32'hFFFFFFFF, 2};
    vecs[6]  = '{2'b11, 32'd5,        32'd0,        5'd11, 32'd5,        2};
    vecs[7]  = '{2'b00, 32'hFFFFFFF9, 32'd0,        5'd12, 32'hFFFFFFFF, 2};
    vecs[8]  = '{2'b10, 32'hFFFFFFF9, 32'd0,        5'd13, 32'hFFFFFFF9, 2};
    vecs[9]  = '{2'b01, 32'd1000,     32'd9,        5'd14, 32'd111,      34};
    vecs[10] = '{2'b11, 32'd1000,     32'd9,        5'd15, 32'd1,        CL};
    vecs[11] = '{2'b00, 32'd100,      32'hFFFFFFF9, 5'd16, 32'hFFFFFFF2, 34};
    vecs[12] = '{2'b10, 32'd100,      32'hFFFFFFF9, 5'd17, 32'd2,        CL};
    vecs[13] = '{2'b01, 32'hFFFFFFFF, 32'd1,        5'd18, 32'hFFFFFFFF, 34};
    vecs[14] = '{2'b11, 32'd7,        32'd9,        5'd19, 32'd7,        34};
    vecs[15] = '{2'b01, 32'h80000000, 32'hFFFFFFFF, 5'd20, 32'd0,        34};
    vecs[16] = '{2'b00, 32'hFFFFFF9C, 32'hFFFFFFF9, 5'd21, 32'd14,       34};
    vecs[17] = '{2'b10, 32'hFFFFFF9C, 32'hFFFFFFF9, 5'd22, 32'hFFFFFFFE, CL};

    v64s[0] = '{2'b01, 64'hFFFFFFFFFFFFFFFF, 64'd3, 5'd1, 64'h5555555555555555, 34};
    v64s[1] = '{2'b11, 64'hFFFFFFFFFFFFFFFF, 64'd3, 5'd2, 64'd0, CL};
    v64s[2] = '{2'b00, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 5'd3, 64'h8000000000000000, 2};
    v64s[3] = '{2'b00, 64'hFFFFFFFFFFFFFF9C, 64'd7, 5'd4, 64'hFFFFFFFFFFFFFFF2, 34};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset ready", rdy32, 1);
    chk("reset wb_valid", wbv32, 0);
    chk("reset wb_value", wbval32, 0);
    chk("reset wb_rd", wbrd32, 0);

    // Back-to-back table: each entry issues in the writeback cycle of the last.
    for (int i = 0; i < 18; i++) begin
      run32(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, lat, val, rdo, bad);
      chk($sformatf("v%0d latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d value", i), val, vecs[i].exp);
      chk($sformatf("v%0d rd", i), rdo, vecs[i].rd);
      chk($sformatf("v%0d ready-high while busy", i), bad, 0);
    end
    @(negedge clk);
    chk("strobe one cycle", wbv32, 0);

    // Request while busy is ignored.
    v32 = 1'b1; op32 = 2'b01; a32 = 32'd100; b32 = 32'd7; rd32 = 5'd23;
    @(posedge clk); #1 v32 = 1'b0;
    repeat (4) @(negedge clk);
    v32 = 1'b1; a32 = 32'd50; b32 = 32'd5; rd32 = 5'd24;
    @(posedge clk); #1 v32 = 1'b0;
    lat = 0; val = '0; rdo = '0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (wbv32) begin lat = 1; val = wbval32; rdo = wbrd32; break; end
    end
    chk("busy-ignore wb seen", lat, 1);
    chk("busy-ignore value", val, 14);
    chk("busy-ignore rd", rdo, 23);
    count_wb32(40, nwb);
    chk("busy-ignore no extra wb", nwb, 0);

    // Flush at T+10.
    v32 = 1'b1; op32 = 2'b01; a32 = 32'd1000; b32 = 32'd7; rd32 = 5'd25;
    @(posedge clk); #1 v32 = 1'b0;
    repeat (10) @(negedge clk);
    fl32 = 1'b1;
    @(posedge clk); #1 fl32 = 1'b0;
    @(negedge clk);
    chk("flush ready T+11", rdy32, 1);
    count_wb32(40, nwb);
    chk("flush no wb", nwb, 0);

    // Request coincident with flush is ignored.
    v32 = 1'b1; fl32 = 1'b1;
    @(posedge clk); #1 v32 = 1'b0; fl32 = 1'b0;
    @(negedge clk);
    chk("valid+flush ready", rdy32, 1);
    count_wb32(40, nwb);
    chk("valid+flush no wb", nwb, 0);

    // Flush in the DONE cycle (T+33) cancels the T+34 writeback.
    v32 = 1'b1; op32 = 2'b01; a32 = 32'd1000; b32 = 32'd7; rd32 = 5'd26;
    @(posedge clk); #1 v32 = 1'b0;
    repeat (33) @(negedge clk);
    chk("done-flush ready low", rdy32, 0);
    fl32 = 1'b1;
    @(posedge clk); #1 fl32 = 1'b0;
    @(negedge clk);
    chk("done-flush wb suppressed", wbv32, 0);
    count_wb32(20, nwb);
    chk("done-flush no wb", nwb, 0);

    // Aborted operation must not have been cached.
    run32(2'b01, 32'd1000, 32'd7, 5'd27, lat, val, rdo, bad);
    chk("after-flush latency", lat, 34);
    chk("after-flush value", val, 142);

    // Reset mid-operation.
    @(negedge clk);
    v32 = 1'b1; op32 = 2'b01; a32 = 32'd2000; b32 = 32'd7; rd32 = 5'd28;
    @(posedge clk); #1 v32 = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst ready", rdy32, 1);
    chk("midrst wb_valid", wbv32, 0);
    chk("midrst wb_value", wbval32, 0);
    chk("midrst wb_rd", wbrd32, 0);
    count_wb32(40, nwb);
    chk("midrst no wb", nwb, 0);

    // Cache contents do not survive reset.
    run32(2'b01, 32'd1000, 32'd7, 5'd29, lat, val, rdo, bad);
    chk("post-reset latency", lat, 34);
    chk("post-reset value", val, 142);

    // 64-bit, 2 bits per cycle.
    @(negedge clk);
    chk("64 reset-idle ready", rdy64, 1);
    for (int i = 0; i < 4; i++) begin
      run64(v64s[i].op, v64s[i].a, v64s[i].b, v64s[i].rd, lat, val64, rdo, bad);
      chk($sformatf("w%0d latency", i), lat, v64s[i].lat);
      chk($sformatf("w%0d value", i), val64, v64s[i].exp);
      chk($sformatf("w%0d rd", i), rdo, v64s[i].rd);
      chk($sformatf("w%0d ready-high while busy", i), bad, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
